// File: rtl/corelet_ctrl.sv
// Instruction sequencer for the corelet: weight fetch/load/flush, activation fetch/execute, OFIFO drain to pmem.
// Optional cycle counter port cycle_cnt is built when CORELET_CTRL_PERF_EN is defined.
module corelet_ctrl #(
   parameter int unsigned row    = 8,
   parameter int unsigned col    = 8,
   parameter int unsigned addr_w = 11,
   parameter int unsigned cnt_w  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [cnt_w-1:0]  num_x,
   input  logic [cnt_w-1:0]  num_k,
   input  logic [addr_w-1:0] w_base,
   input  logic              ofifo_o_valid,
   output logic [34:0]       inst,
   output logic              xmem_cen,
   output logic [addr_w-1:0] xmem_addr,
   output logic              pmem_cen,
   output logic              pmem_wen,
   output logic [addr_w-1:0] pmem_addr,
   output logic              busy,
   output logic              done
`ifdef CORELET_CTRL_PERF_EN
   ,
   output logic [31:0]       cycle_cnt
`endif
);

   localparam int unsigned INST_W   = 35;
   localparam int unsigned FLUSH_N  = row + col;
   localparam int unsigned FLUSH_CW = $clog2(FLUSH_N + 1);
   localparam int unsigned BEAT_W   = (cnt_w > FLUSH_CW) ? cnt_w : FLUSH_CW;
   localparam int unsigned LOAD     = 0;
   localparam int unsigned EXEC     = 1;
   localparam int unsigned L0_WR    = 2;
   localparam int unsigned L0_RD    = 3;
   localparam int unsigned OFIFO_RD = 6;

   typedef enum logic [2:0] {
      IDLE, W_FETCH, W_LOAD, W_FLUSH, X_FETCH, X_EXEC, DRAIN, DONE
   } state_t;

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [cnt_w-1:0]    k_q, k_d, nx_q, nx_d, nk_q, nk_d;
   logic [cnt_w-1:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [addr_w-1:0]   w_ptr_q, w_ptr_d, p_ptr_q, p_ptr_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic                xmem_cen_q, xmem_cen_d, pmem_cen_q, pmem_cen_d, pmem_wen_q, pmem_wen_d;
   logic [addr_w-1:0]   xmem_addr_q, xmem_addr_d, pmem_addr_q, pmem_addr_d;
   logic                busy_q, busy_d, done_q, done_d;

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         k_q         <= '0;
         nx_q        <= '0;
         nk_q        <= '0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         w_ptr_q     <= '0;
         p_ptr_q     <= '0;
         inst_q      <= '0;
         xmem_cen_q  <= 1'b1;
         xmem_addr_q <= '0;
         pmem_cen_q  <= 1'b1;
         pmem_wen_q  <= 1'b1;
         pmem_addr_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         k_q         <= k_d;
         nx_q        <= nx_d;
         nk_q        <= nk_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         w_ptr_q     <= w_ptr_d;
         p_ptr_q     <= p_ptr_d;
         inst_q      <= inst_d;
         xmem_cen_q  <= xmem_cen_d;
         xmem_addr_q <= xmem_addr_d;
         pmem_cen_q  <= pmem_cen_d;
         pmem_wen_q  <= pmem_wen_d;
         pmem_addr_q <= pmem_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next state and next output values
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      k_d         = k_q;
      nx_d        = nx_q;
      nk_d        = nk_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      w_ptr_d     = w_ptr_q;
      p_ptr_d     = p_ptr_q;
      inst_d      = '0;
      xmem_cen_d  = 1'b1;
      xmem_addr_d = xmem_addr_q;
      pmem_cen_d  = 1'b1;
      pmem_wen_d  = 1'b1;
      pmem_addr_d = pmem_addr_q;
      done_d      = 1'b0;

      // SRAM read data lands one cycle after the request; OFIFO row likewise goes to pmem next cycle
      inst_d[L0_WR] = ~xmem_cen_q;
      if (inst_q[OFIFO_RD]) begin
         pmem_cen_d  = 1'b0;
         pmem_wen_d  = 1'b0;
         pmem_addr_d = p_ptr_q;
         p_ptr_d     = p_ptr_q + addr_w'(1);
         wr_cnt_d    = wr_cnt_q + cnt_w'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               nx_d    = (num_x == '0) ? cnt_w'(1) : num_x;
               nk_d    = (num_k == '0) ? cnt_w'(1) : num_k;
               w_ptr_d = w_base;
               p_ptr_d = '0;
               k_d     = '0;
               beat_d  = '0;
               state_d = W_FETCH;
            end
         end
         W_FETCH: begin
            xmem_cen_d  = 1'b0;
            xmem_addr_d = w_ptr_q;
            w_ptr_d     = w_ptr_q + addr_w'(1);
            beat_d      = beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(col - 1)) begin
               beat_d  = '0;
               state_d = W_LOAD;
            end
         end
         W_LOAD: begin
            inst_d[L0_RD] = 1'b1;
            inst_d[LOAD]  = 1'b1;
            beat_d        = beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(col - 1)) begin
               beat_d  = '0;
               state_d = W_FLUSH;
            end
         end
         W_FLUSH: begin
            beat_d = beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(FLUSH_N - 1)) begin
               beat_d  = '0;
               state_d = X_FETCH;
            end
         end
         X_FETCH: begin
            xmem_cen_d  = 1'b0;
            xmem_addr_d = addr_w'(beat_q);
            beat_d      = beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(nx_q - cnt_w'(1))) begin
               beat_d  = '0;
               state_d = X_EXEC;
            end
         end
         X_EXEC: begin
            inst_d[L0_RD] = 1'b1;
            inst_d[EXEC]  = 1'b1;
            beat_d        = beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(nx_q - cnt_w'(1))) begin
               beat_d   = '0;
               rd_cnt_d = '0;
               wr_cnt_d = '0;
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            if (ofifo_o_valid && (rd_cnt_q < nx_q)) begin
               inst_d[OFIFO_RD] = 1'b1;
               rd_cnt_d         = rd_cnt_q + cnt_w'(1);
            end
            // Leave once the final row's pmem write is being issued
            if (inst_q[OFIFO_RD] && (wr_cnt_q == nx_q - cnt_w'(1))) begin
               if (k_q != nk_q - cnt_w'(1)) begin
                  k_d     = k_q + cnt_w'(1);
                  beat_d  = '0;
                  state_d = W_FETCH;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_q != IDLE) && (state_q != DONE);
   end

   assign inst      = inst_q;
   assign xmem_cen  = xmem_cen_q;
   assign xmem_addr = xmem_addr_q;
   assign pmem_cen  = pmem_cen_q;
   assign pmem_wen  = pmem_wen_q;
   assign pmem_addr = pmem_addr_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef CORELET_CTRL_PERF_EN
   logic [31:0] cycle_cnt_q;

   // Busy-cycle counter: cleared by an accepted start, saturating
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         cycle_cnt_q <= '0;
      end else if (busy_q && (cycle_cnt_q != '1)) begin
         cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl: records an output trace per pass and checks it against
// sequences derived from the pass parameters (read/write address lists, beat counts, latencies).
module tb_corelet_ctrl;
   localparam int unsigned COL = 8;
   localparam int unsigned ROW = 8;
   localparam int unsigned AW  = 11;
   localparam int unsigned CW  = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [CW-1:0] num_x, num_k;
   logic [AW-1:0] w_base;
   logic          ofifo_o_valid = 1'b0;
   logic [34:0]   inst;
   logic          xmem_cen, pmem_cen, pmem_wen, busy, done;
   logic [AW-1:0] xmem_addr, pmem_addr;
`ifdef CORELET_CTRL_PERF_EN
   logic [31:0]   cycle_cnt;
`endif

   corelet_ctrl #(.row(ROW), .col(COL), .addr_w(AW), .cnt_w(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .num_x(num_x), .num_k(num_k),
      .w_base(w_base), .ofifo_o_valid(ofifo_o_valid), .inst(inst),
      .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .pmem_cen(pmem_cen),
      .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .busy(busy), .done(done)
`ifdef CORELET_CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [34:0]   inst;
      logic          xcen, pcen, pwen, busy, done, valid;
      logic [AW-1:0] xaddr, paddr;
   } cyc_t;

   cyc_t tr[$];
   bit   mon_en = 0;
   int   vmode = 0;
   bit   pat_go = 0;
   bit   prev_exec = 0;
   int   pidx = 0;
   logic [4:0] pat = 5'b11001;  // applied LSB first: 1,0,0,1,1
   int   checks = 0, passes = 0, fails = 0;

   // Trace recorder, sampled mid-cycle
   always @(negedge clk) begin
      cyc_t c;
      if (mon_en) begin
         c.inst = inst; c.xcen = xmem_cen; c.xaddr = xmem_addr; c.pcen = pmem_cen;
         c.pwen = pmem_wen; c.paddr = pmem_addr; c.busy = busy; c.done = done;
         c.valid = ofifo_o_valid;
         tr.push_back(c);
         if (vmode == 2 && prev_exec && !inst[1]) pat_go = 1;
         prev_exec = inst[1];
      end else begin
         pat_go = 0;
         prev_exec = 0;
      end
   end

   // OFIFO valid driver: tied high, random, or a fixed pattern once execute ends
   always @(posedge clk) begin
      #1;
      case (vmode)
         0: ofifo_o_valid = 1'b1;
         1: ofifo_o_valid = 1'($urandom_range(0, 1));
         default: begin
            if (pat_go && pidx < 5) begin
               ofifo_o_valid = pat[pidx];
               pidx++;
            end else begin
               ofifo_o_valid = 1'b0;
            end
            if (!pat_go) pidx = 0;
         end
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run(input int nx, input int nk, input int wb, input int mode, input bit restart);
      bit got;
      tr.delete();
      vmode = mode;
      @(posedge clk); #1;
      mon_en = 1;
      num_x = CW'(nx); num_k = CW'(nk); w_base = AW'(wb); start = 1;
      @(posedge clk); #1;
      start = 0;
      num_x = CW'($urandom_range(1, 9)); num_k = CW'($urandom_range(1, 5)); w_base = AW'($urandom);
      got = 0;
      for (int n = 0; n < 20000 && !got; n++) begin
         @(negedge clk);
         if (done) got = 1;
         else if (restart && (n == 6 || n == 30)) begin
            #1 start = 1;
            @(posedge clk); #1 start = 0;
         end
      end
      check("done_seen", 64'(got), 64'd1);
      repeat (3) @(negedge clk);
      mon_en = 0;
   endtask

   task automatic analyze(input int nx_in, input int nk, input int wb);
      int nx;
      int exp_x[$], exp_p[$], got_x[$], got_p[$], flush[$];
      int n, v_l0, v_ld, v_ex, v_hi, v_pw, v_rv, v_pe, v_bd, v_busy;
      int l0cnt, ldcnt, excnt, rdcnt, dcnt, dpos, fx, lw;
      nx = (nx_in == 0) ? 1 : nx_in;
      n = tr.size();
      v_l0 = 0; v_ld = 0; v_ex = 0; v_hi = 0; v_pw = 0; v_rv = 0; v_pe = 0; v_bd = 0; v_busy = 0;
      l0cnt = 0; ldcnt = 0; excnt = 0; rdcnt = 0; dcnt = 0; dpos = -1; fx = -1; lw = -1;
      for (int k = 0; k < nk; k++) begin
         for (int i = 0; i < int'(COL); i++) exp_x.push_back((wb + k * int'(COL) + i) % (1 << AW));
         for (int i = 0; i < nx; i++) exp_x.push_back(i);
      end
      for (int i = 0; i < nk * nx; i++) exp_p.push_back(i);

      for (int t = 0; t < n; t++) begin
         bit prev_rd, prev_of, prev_v;
         prev_rd = (t > 0) ? !tr[t-1].xcen : 1'b0;
         prev_of = (t > 0) ? tr[t-1].inst[6] : 1'b0;
         prev_v  = (t > 0) ? tr[t-1].valid : 1'b0;
         if (!tr[t].xcen) begin got_x.push_back(int'(tr[t].xaddr)); if (fx < 0) fx = t; end
         if (!tr[t].pcen) begin got_p.push_back(int'(tr[t].paddr)); lw = t; end
         if (tr[t].inst[2] !== prev_rd) v_l0++;
         if (tr[t].inst[0] && !tr[t].inst[3]) v_ld++;
         if (tr[t].inst[1] && (!tr[t].inst[3] || tr[t].inst[0])) v_ex++;
         if (tr[t].inst[34:7] != '0) v_hi++;
         if ((!tr[t].pcen) !== prev_of) v_pw++;
         if (tr[t].inst[6] && !prev_v) v_rv++;
         if (tr[t].pwen !== tr[t].pcen) v_pe++;
         l0cnt += int'(tr[t].inst[2]);
         ldcnt += int'(tr[t].inst[0]);
         excnt += int'(tr[t].inst[1]);
         rdcnt += int'(tr[t].inst[6]);
         if (tr[t].done) begin dcnt++; dpos = t; if (tr[t].busy) v_bd++; end
         if (tr[t].inst[0] && (t + 1 >= n || !tr[t+1].inst[0])) begin
            int g, u;
            g = 0; u = t + 1;
            while (u < n && tr[u].inst == '0 && tr[u].xcen) begin g++; u++; end
            flush.push_back(g);
         end
      end
      for (int t = fx; t >= 0 && t <= lw; t++) if (!tr[t].busy) v_busy++;

      check("xrd_len", 64'(got_x.size()), 64'(exp_x.size()));
      for (int i = 0; i < got_x.size() && i < exp_x.size(); i++)
         check($sformatf("xrd_addr[%0d]", i), 64'(got_x[i]), 64'(exp_x[i]));
      check("pwr_len", 64'(got_p.size()), 64'(exp_p.size()));
      for (int i = 0; i < got_p.size() && i < exp_p.size(); i++)
         check($sformatf("pwr_addr[%0d]", i), 64'(got_p[i]), 64'(exp_p[i]));
      check("l0wr_follows_read", 64'(v_l0), 64'd0);
      check("l0wr_cnt", 64'(l0cnt), 64'((int'(COL) + nx) * nk));
      check("load_cnt", 64'(ldcnt), 64'(int'(COL) * nk));
      check("exec_cnt", 64'(excnt), 64'(nx * nk));
      check("load_with_l0rd", 64'(v_ld), 64'd0);
      check("exec_with_l0rd", 64'(v_ex), 64'd0);
      check("upper_bits_zero", 64'(v_hi), 64'd0);
      check("pwr_follows_ofrd", 64'(v_pw), 64'd0);
      check("ofrd_only_valid", 64'(v_rv), 64'd0);
      check("ofrd_cnt", 64'(rdcnt), 64'(nx * nk));
      check("pwen_eq_pcen", 64'(v_pe), 64'd0);
      check("flush_groups", 64'(flush.size()), 64'(nk));
      foreach (flush[i]) check($sformatf("flush_len[%0d]", i), 64'(flush[i]), 64'(ROW + COL));
      check("done_cnt", 64'(dcnt), 64'd1);
      check("done_after_last_wr", 64'(dpos > lw), 64'd1);
      check("busy_low_at_done", 64'(v_bd), 64'd0);
      check("busy_through_pass", 64'(v_busy), 64'd0);
   endtask

   initial begin
      bit seen;
      reset = 0; start = 0; num_x = '0; num_k = '0; w_base = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_inst", 64'(inst), 64'd0);
      check("rst_xcen", 64'(xmem_cen), 64'd1);
      check("rst_xaddr", 64'(xmem_addr), 64'd0);
      check("rst_pcen", 64'(pmem_cen), 64'd1);
      check("rst_pwen", 64'(pmem_wen), 64'd1);
      check("rst_paddr", 64'(pmem_addr), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      @(negedge clk) reset = 1;

      // Asynchronous reset while executing
      vmode = 0;
      @(posedge clk); #1;
      num_x = 8'd4; num_k = 8'd2; w_base = 11'd100; start = 1;
      @(posedge clk); #1 start = 0;
      seen = 0;
      for (int n = 0; n < 500 && !seen; n++) begin
         @(negedge clk);
         if (inst[1]) seen = 1;
      end
      check("exec_reached", 64'(seen), 64'd1);
      #2 reset = 0;
      #1;
      check("midrst_inst", 64'(inst), 64'd0);
      check("midrst_xcen", 64'(xmem_cen), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_pcen", 64'(pmem_cen), 64'd1);
      @(negedge clk) reset = 1;

      run(4, 1, 64, 0, 0);
      analyze(4, 1, 64);
`ifdef CORELET_CTRL_PERF_EN
      begin
         int bc;
         bc = 0;
         foreach (tr[i]) bc += int'(tr[i].busy);
         check("cycle_cnt", 64'(cycle_cnt), 64'(bc));
         repeat (5) @(negedge clk);
         check("cycle_cnt_hold", 64'(cycle_cnt), 64'(bc));
      end
`endif
      run(2, 3, 200, 0, 0);
      analyze(2, 3, 200);
      run(3, 1, 10, 2, 0);
      analyze(3, 1, 10);
      run(3, 2, 50, 0, 1);
      analyze(3, 2, 50);
      run(0, 2, 2044, 1, 0);
      analyze(0, 2, 2044);
      for (int r = 0; r < 4; r++) begin
         int nx, nk, wb;
         nx = int'($urandom_range(1, 5));
         nk = int'($urandom_range(1, 3));
         wb = int'($urandom_range(0, 2047));
         run(nx, nk, wb, 1, 0);
         analyze(nx, nk, wb);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
- Instruction sequencer that produces the 35-bit inst word and the memory strobes consumed by the corelet.
- Runs one convolution pass per start pulse:
  - weight fetch into L0, weight load into the MAC array, array flush;
  - activation fetch, execute;
  - drains OFIFO results to psum memory.
- Loops over num_k kernel positions, then raises done.
- Sits between the top-level testbench/host and the corelet plus activation (xmem) and psum (pmem) SRAMs.

Parameters:
- row, 8, MAC array rows / L0 lanes
- col, 8, MAC array columns / OFIFO lanes
- addr_w, 11, SRAM address width
- cnt_w, 8, width of num_x / num_k config counters

Ports:
- clk  in  1  master clock
- reset  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  one-cycle pulse; accepted only in IDLE
- num_x  in  cnt_w  activation vectors per kernel pass (1..255), sampled on start
- num_k  in  cnt_w  kernel positions (1..255), sampled on start
- w_base  in  addr_w  xmem base address of weights, sampled on start
- ofifo_o_valid  in  1  corelet OFIFO has a full row
- inst  out  35  corelet instruction word
- xmem_cen  out  1  xmem chip enable, active-low
- xmem_addr  out  addr_w  xmem address
- pmem_cen  out  1  pmem chip enable, active-low
- pmem_wen  out  1  pmem write enable, active-low
- pmem_addr  out  addr_w  pmem address
- busy  out  1  high outside IDLE/DONE
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset values:
  - inst = 0
  - xmem_cen = 1, pmem_cen = 1, pmem_wen = 1
  - xmem_addr = 0, pmem_addr = 0
  - busy = 0, done = 0
  - FSM = IDLE, all counters 0
- All outputs are registered.
- inst bit map (all other bits driven 0):
  - [0] load, [1] execute, [2] l0_wr, [3] l0_rd, [4] ififo_rd, [5] ififo_wr, [6] ofifo_rd
  - [33] acc, [34] relu: always 0 in this block
- xmem is read-only from this block (write enable not driven).
- xmem and pmem are synchronous-read SRAMs with 1-cycle latency.
  - Any xmem read issued in cycle t must have l0_wr asserted in cycle t+1.
  - Any ofifo_rd in cycle t must be followed by a pmem write in cycle t+1.
- FSM states and transitions (k = kernel index, i = beat counter):
  - IDLE: on start, latch config, k = 0 -> W_FETCH. A start seen in any other state is ignored.
  - W_FETCH, col beats:
    - xmem_cen = 0, xmem_addr = w_base + k*col + i
    - l0_wr trails by one cycle; the last l0_wr occurs in the first cycle of W_LOAD.
    - -> W_LOAD
  - W_LOAD, col beats: l0_rd = 1, load = 1. -> W_FLUSH
  - W_FLUSH: all-zero inst for row+col cycles. -> X_FETCH
  - X_FETCH, num_x beats:
    - xmem_cen = 0, xmem_addr = i (activations at 0..num_x-1)
    - l0_wr trails by one cycle
    - -> X_EXEC
  - X_EXEC, num_x beats: l0_rd = 1, execute = 1. -> DRAIN
  - DRAIN:
    - Whenever ofifo_o_valid = 1, assert ofifo_rd for one cycle.
    - Next cycle: pmem_cen = 0, pmem_wen = 0, pmem_addr = k*num_x + j, where j = 0..num_x-1 counts rows read.
    - After the num_x-th pmem write: if k+1 < num_k, k++ and -> W_FETCH; else -> DONE.
  - DONE: done = 1 for one cycle. -> IDLE
- ofifo_rd is never asserted while ofifo_o_valid = 0. Back-to-back reads are allowed when valid stays high.
- DRAIN has no timeout; it waits indefinitely for ofifo_o_valid.
- Address arithmetic is modulo 2^addr_w.
- num_x = 0 or num_k = 0: treated as 1.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous); no partial done.

Optional Feature:
- Macro: CORELET_CTRL_PERF_EN.
- Defined: adds output cycle_cnt [31:0]. It clears on an accepted start, increments every cycle while busy = 1, holds its value in DONE/IDLE, and saturates at 0xFFFFFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset during X_EXEC (reset = 0 for 1 cycle) -> inst = 0, xmem_cen = 1, busy = 0 on the same edge; a later start runs cleanly from k = 0.
- num_k = 1, num_x = 4, w_base = 64, ofifo_o_valid tied 1 in DRAIN:
  - xmem reads addrs 64..71, then 0..3
  - l0_wr is high exactly 12 cycles, each one cycle after its read
  - 8 load cycles, then a flush of exactly 16 zero cycles
  - 4 execute cycles
  - pmem writes to 0..3
  - done pulses once
- num_k = 3, num_x = 2:
  - weight reads are w_base+0..7, +8..15, +16..23
  - pmem writes are 0,1 / 2,3 / 4,5
  - exactly one done pulse
- ofifo_o_valid toggling 1,0,0,1,1 in DRAIN (num_x = 3) -> ofifo_rd only in valid cycles; pmem writes lag by exactly 1 cycle; no extra reads.
- start pulsed again while busy -> ignored; latched config unchanged; output trace identical to the single-start run.
- With CORELET_CTRL_PERF_EN: num_k = 1, num_x = 4, valid tied 1 -> cycle_cnt equals the measured busy-high cycle count, and it holds after done.
